// File: rtl/int_ctrl8_pkg.sv
// Shared types and constants for the eight-source interrupt controller.
package int_ctrl8_pkg;

  localparam int unsigned NSRC = 8;
  localparam int unsigned VW   = 3;

  localparam logic [NSRC-1:0] MASK_RST = 8'hFF;
  localparam logic [VW-1:0]   VEC_IDLE = 3'b111;
  localparam logic [VW-1:0]   PTR_RST  = 3'd7;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StService = 2'd2
  } state_e;

endpackage

// File: rtl/int_ctrl8_prio_enc8.sv
// Combinational 8-to-3 priority search: starts at ptr_i and walks downward
// with wrap-around, returning the first set bit of eligible_i.
module prio_enc8
  import int_ctrl8_pkg::*;
(
  input  logic [NSRC-1:0] eligible_i,
  input  logic [VW-1:0]   ptr_i,
  output logic [VW-1:0]   idx_o,
  output logic            valid_o
);

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    logic [VW-1:0] cand;
    cand    = '0;
    idx_o   = VEC_IDLE;
    valid_o = 1'b0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      cand = ptr_i - VW'(k);
      if (eligible_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl8.sv
// Eight-source interrupt controller with irq/ack/eoi handshake.
// Falling edges on req_n pend a source; the highest-priority unmasked pending
// source is offered to the CPU. Define ROTATE_PRIO_EN to make the serviced
// source the lowest priority after its eoi; otherwise priority is fixed 7..0.
module int_ctrl8
  import int_ctrl8_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] req_n,
  input  logic            mask_wr,
  input  logic [NSRC-1:0] mask_din,
  output logic [NSRC-1:0] mask_q,
  output logic            irq_n,
  output logic [VW-1:0]   vec,
  input  logic            ack,
  input  logic            eoi,
  output logic            busy,
  output logic            timeout
);

  localparam logic [7:0] CntLimit = 8'(ACK_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NSRC-1:0] prev_n_q, pend_q, pend_d, mask_d;
  logic [NSRC-1:0] set, clr, eligible;
  logic [VW-1:0]   vec_q, vec_d;
  logic [VW-1:0]   enc_idx;
  logic            enc_valid;
  logic            irq_n_q, irq_n_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic [VW-1:0]   ptr;

`ifdef ROTATE_PRIO_EN
  logic [VW-1:0]   ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = PTR_RST;
`endif

  assign set      = prev_n_q & ~req_n;
  assign eligible = pend_q & ~mask_q;
  // A fresh edge on the source being acked wins over the clear.
  assign pend_d   = (pend_q & ~clr) | set;
  assign mask_d   = mask_wr ? mask_din : mask_q;

  prio_enc8 u_prio_enc8 (
    .eligible_i (eligible),
    .ptr_i      (ptr),
    .idx_o      (enc_idx),
    .valid_o    (enc_valid)
  );

  // Handshake sequencing and next-state of the registered outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vec_d     = vec_q;
    clr       = '0;
    timeout_d = 1'b0;
`ifdef ROTATE_PRIO_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      StIdle: begin
        if (enc_valid) begin
          vec_d   = enc_idx;
          cnt_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (ack) begin
          clr     = NSRC'(1) << vec_q;
          state_d = StService;
        end else if (cnt_q == CntLimit) begin
          // Withdraw the request but leave it pending for another try.
          state_d   = StIdle;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StService: begin
        if (eoi) begin
          state_d = StIdle;
`ifdef ROTATE_PRIO_EN
          ptr_d   = vec_q - VW'(1);
`endif
        end
      end
      default: state_d = StIdle;
    endcase
    irq_n_d = (state_d != StReq);
    busy_d  = (state_d == StService);
  end

  // All state and outputs are registered; reset discards pending events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      prev_n_q  <= '1;
      pend_q    <= '0;
      mask_q    <= MASK_RST;
      vec_q     <= VEC_IDLE;
      irq_n_q   <= 1'b1;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_n_q  <= req_n;
      pend_q    <= pend_d;
      mask_q    <= mask_d;
      vec_q     <= vec_d;
      irq_n_q   <= irq_n_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef ROTATE_PRIO_EN
  // Rotating priority pointer, moved only by eoi.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PTR_RST;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign irq_n   = irq_n_q;
  assign vec     = vec_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_int_ctrl8.sv
// Directed self-checking bench for int_ctrl8 (ACK_TIMEOUT = 15).
module tb_int_ctrl8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_n;
  logic       mask_wr;
  logic [7:0] mask_din;
  logic [7:0] mask_q;
  logic       irq_n;
  logic [2:0] vec;
  logic       ack;
  logic       eoi;
  logic       busy;
  logic       timeout;

  int n_tests;
  int n_fail;

  int_ctrl8 #(
    .ACK_TIMEOUT (15)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_n    (req_n),
    .mask_wr  (mask_wr),
    .mask_din (mask_din),
    .mask_q   (mask_q),
    .irq_n    (irq_n),
    .vec      (vec),
    .ack      (ack),
    .eoi      (eoi),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [7:0] lines);
    req_n = ~lines;
    tick();
    req_n = 8'hFF;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic do_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_vec;
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    req_n    = 8'hFF;
    mask_wr  = 1'b0;
    mask_din = 8'h00;
    ack      = 1'b0;
    eoi      = 1'b0;
    tick();
    tick();
    check_eq("rst_mask", mask_q, 8'hFF);
    check_eq("rst_irq_n", irq_n, 1'b1);
    check_eq("rst_vec", vec, 3'd7);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_timeout", timeout, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single source 3: full handshake.
    mask_wr  = 1'b1;
    mask_din = 8'h00;
    tick();
    mask_wr = 1'b0;
    check_eq("mask_write", mask_q, 8'h00);
    pulse_req(8'h08);
    check_eq("t1_irq_wait", irq_n, 1'b1);
    tick();
    check_eq("t1_irq_low", irq_n, 1'b0);
    check_eq("t1_vec", vec, 3'd3);
    do_ack();
    check_eq("t1_ack_irq", irq_n, 1'b1);
    check_eq("t1_ack_busy", busy, 1'b1);
    check_eq("t1_svc_vec", vec, 3'd3);
    do_eoi();
    check_eq("t1_eoi_busy", busy, 1'b0);
    do_ack();
    check_eq("ack_in_idle_busy", busy, 1'b0);
    check_eq("ack_in_idle_irq", irq_n, 1'b1);

    // Sources 2 and 5 together: 5 first, then 2.
    pulse_req(8'h24);
    tick();
    check_eq("t2_irq_low", irq_n, 1'b0);
    check_eq("t2_vec_first", vec, 3'd5);
    do_eoi();
    check_eq("eoi_in_req_irq", irq_n, 1'b0);
    check_eq("eoi_in_req_busy", busy, 1'b0);
    do_ack();
    check_eq("t2_busy", busy, 1'b1);
    do_eoi();
    check_eq("t2_idle_gap", irq_n, 1'b1);
    tick();
    check_eq("t2_irq_second", irq_n, 1'b0);
    check_eq("t2_vec_second", vec, 3'd2);
    do_ack();
    do_eoi();
    tick();
    check_eq("t2_drained", irq_n, 1'b1);

    // Masked source 5 held pending, then released by unmasking.
    mask_wr  = 1'b1;
    mask_din = 8'h20;
    tick();
    mask_wr = 1'b0;
    pulse_req(8'h20);
    tick();
    check_eq("t3_masked_a", irq_n, 1'b1);
    tick();
    check_eq("t3_masked_b", irq_n, 1'b1);
    mask_wr  = 1'b1;
    mask_din = 8'h00;
    tick();
    mask_wr = 1'b0;
    check_eq("t3_unmask_edge", irq_n, 1'b1);
    tick();
    check_eq("t3_unmasked_irq", irq_n, 1'b0);
    check_eq("t3_unmasked_vec", vec, 3'd5);
    do_ack();
    do_eoi();

    // Source 1 never acked: 15 cycles low, timeout pulse, retry.
    pulse_req(8'h02);
    tick();
    check_eq("t4_irq_low_0", irq_n, 1'b0);
    for (int i = 1; i < 15; i++) begin
      tick();
      check_eq($sformatf("t4_irq_low_%0d", i), irq_n, 1'b0);
      check_eq($sformatf("t4_no_to_%0d", i), timeout, 1'b0);
    end
    tick();
    check_eq("t4_expire_irq", irq_n, 1'b1);
    check_eq("t4_expire_pulse", timeout, 1'b1);
    tick();
    check_eq("t4_retry_irq", irq_n, 1'b0);
    check_eq("t4_pulse_end", timeout, 1'b0);
    check_eq("t4_retry_vec", vec, 3'd1);
    do_ack();
    do_eoi();

    // Re-pend of source 4 coinciding with its ack.
    pulse_req(8'h10);
    tick();
    check_eq("t5_vec", vec, 3'd4);
    ack   = 1'b1;
    req_n = 8'hEF;
    tick();
    ack   = 1'b0;
    req_n = 8'hFF;
    check_eq("t5_busy", busy, 1'b1);
    do_eoi();
    check_eq("t5_eoi_busy", busy, 1'b0);
    tick();
    check_eq("t5_regrant_irq", irq_n, 1'b0);
    check_eq("t5_regrant_vec", vec, 3'd4);
    do_ack();
    do_eoi();

    // Sources 7 and 6 re-pend every round.
    pulse_req(8'hC0);
    tick();
    for (int r = 0; r < 4; r++) begin
`ifdef ROTATE_PRIO_EN
      exp_vec = (r % 2 == 0) ? 3'd7 : 3'd6;
`else
      exp_vec = 3'd7;
`endif
      check_eq($sformatf("t6_irq_r%0d", r), irq_n, 1'b0);
      check_eq($sformatf("t6_vec_r%0d", r), vec, exp_vec);
      do_ack();
      pulse_req(8'h01 << exp_vec);
      do_eoi();
      tick();
    end

    // Asynchronous reset in the middle of a request.
    check_eq("t7_pre_irq", irq_n, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t7_async_irq", irq_n, 1'b1);
    check_eq("t7_async_vec", vec, 3'd7);
    check_eq("t7_async_mask", mask_q, 8'hFF);
    tick();
    rst_n = 1'b1;
    mask_wr  = 1'b1;
    mask_din = 8'h00;
    tick();
    mask_wr = 1'b0;
    tick();
    tick();
    check_eq("t7_pend_lost", irq_n, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
